// File: rtl/sseg_scan_controller_if.sv
// Bundle between the system logic producing display values, the scan controller,
// and the per-digit sseg driver it feeds.
interface sseg_scan_controller_if;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        load;
    logic        pending;
    logic [2:0]  active;
    logic [3:0]  num;
    logic        dp_ctrl;
    logic        blank;
    logic        frame_done;

    modport master (
        output data_in, dp_in, digit_en, load,
        input  pending, active, num, dp_ctrl, blank, frame_done
    );

    modport slave (
        input  data_in, dp_in, digit_en, load,
        output pending, active, num, dp_ctrl, blank, frame_done
    );
endinterface

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed scan of an 8-digit seven-segment display with a frame-synchronous
// double-buffered image. Optional SSEG_LEADING_ZERO_BLANK_EN drops leading-zero digits.
module sseg_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_W       = 17
) (
    input logic                   clk,
    input logic                   reset_n,
    sseg_scan_controller_if.slave sseg
);

    logic [DIV_W-1:0] r_cnt;
    logic [31:0]      r_p_data, r_s_data;
    logic [7:0]       r_p_dp, r_s_dp, r_p_en, r_s_en;
    logic             r_pending;
    logic [2:0]       r_idx;
    logic [3:0]       r_num;
    logic             r_dp_ctrl, r_blank, r_frame_done;

    logic             w_tick, w_boundary, w_xfer;
    logic [31:0]      w_s_data;
    logic [7:0]       w_s_dp, w_s_en, w_e_old, w_e_new;
    logic [3:0]       w_old, w_new;
    logic [2:0]       w_idx;

    // Returns {found, index} of the first enabled digit circularly after cur.
    function automatic logic [3:0] f_search(input logic [7:0] en, input logic [2:0] cur);
        logic [2:0] cand;
        logic       hit;
        logic [2:0] res;
        hit = 1'b0;
        res = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = cur + 3'(k);
            if (!hit && en[cand]) begin
                hit = 1'b1;
                res = cand;
            end
        end
        return {hit, res};
    endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Digit i survives only if some nibble at or above i is non-zero.
    function automatic logic [7:0] f_keep(input logic [31:0] data);
        logic [7:0] keep;
        logic       nz;
        nz   = 1'b0;
        keep = 8'h01;
        for (int i = 7; i >= 1; i--) begin
            nz      = nz | (|data[4*i +: 4]);
            keep[i] = nz;
        end
        return keep;
    endfunction
`endif

    always_comb begin
        w_tick = (r_cnt == DIV_W'(REFRESH_DIV - 1));
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        w_e_old = r_s_en & f_keep(r_s_data);
`else
        w_e_old = r_s_en;
`endif
        w_old = f_search(w_e_old, r_idx);
        // Nothing found above idx means the search wrapped 7->0 (also covers E == 0).
        w_boundary = w_tick && (!w_old[3] || (w_old[2:0] <= r_idx));
        w_xfer     = w_boundary && r_pending;
        w_s_data   = w_xfer ? r_p_data : r_s_data;
        w_s_dp     = w_xfer ? r_p_dp   : r_s_dp;
        w_s_en     = w_xfer ? r_p_en   : r_s_en;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        w_e_new = w_s_en & f_keep(w_s_data);
`else
        w_e_new = w_s_en;
`endif
        w_new = f_search(w_e_new, r_idx);
        w_idx = w_new[3] ? w_new[2:0] : 3'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_p_data     <= '0;
            r_p_dp       <= '0;
            r_p_en       <= '0;
            r_s_data     <= '0;
            r_s_dp       <= '0;
            r_s_en       <= '0;
            r_pending    <= 1'b0;
            r_idx        <= 3'd0;
            r_num        <= 4'd0;
            r_dp_ctrl    <= 1'b1;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame_done <= w_boundary;
            // A load on a transferring edge refills P after the old P moved to S.
            r_pending    <= sseg.load | (r_pending & ~w_xfer);
            if (sseg.load) begin
                r_p_data <= sseg.data_in;
                r_p_dp   <= sseg.dp_in;
                r_p_en   <= sseg.digit_en;
            end
            if (w_xfer) begin
                r_s_data <= r_p_data;
                r_s_dp   <= r_p_dp;
                r_s_en   <= r_p_en;
            end
            if (w_tick) begin
                r_idx     <= w_idx;
                r_num     <= w_s_data[{w_idx, 2'b00} +: 4];
                r_dp_ctrl <= ~w_s_dp[w_idx];
                r_blank   <= ~w_new[3];
            end
        end
    end

    assign sseg.pending    = r_pending;
    assign sseg.active     = r_idx;
    assign sseg.num        = r_num;
    assign sseg.dp_ctrl    = r_dp_ctrl;
    assign sseg.blank      = r_blank;
    assign sseg.frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Bench for sseg_scan_controller: directed scan scenarios plus random loads/resets,
// checked every cycle against a digit-list model of the scan.
module tb_sseg_scan_controller;
    localparam int unsigned R = 4;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk;
    logic reset_n;
    sseg_scan_controller_if bus ();

    sseg_scan_controller #(
        .REFRESH_DIV(R),
        .DIV_W      (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sseg   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit tb_go = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: displayed image, pending image, current digit, derived from digit lists.
    int          m_age   = 0;
    logic [31:0] m_s_data = '0, m_p_data = '0;
    logic [7:0]  m_s_dp = '0, m_p_dp = '0, m_s_en = '0, m_p_en = '0;
    bit          m_pend  = 1'b0;
    int          m_cur   = 0;
    bit          m_blank = 1'b1;
    bit          m_fd    = 1'b0;
    int          m_above;
    bit          m_bound;

    function automatic bit digit_on(input logic [31:0] d, input logic [7:0] en, input int i);
        bit lz;
        lz = (i != 0) && ((d >> (4 * i)) == 32'd0);
        return en[i] && !(LZB && lz);
    endfunction

    function automatic int next_above(input logic [31:0] d, input logic [7:0] en, input int cur);
        for (int i = cur + 1; i < 8; i++) if (digit_on(d, en, i)) return i;
        return -1;
    endfunction

    function automatic int lowest_on(input logic [31:0] d, input logic [7:0] en);
        for (int i = 0; i < 8; i++) if (digit_on(d, en, i)) return i;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_age = 0; m_s_data = '0; m_p_data = '0; m_s_dp = '0; m_p_dp = '0;
            m_s_en = '0; m_p_en = '0; m_pend = 0; m_cur = 0; m_blank = 1; m_fd = 0;
        end else begin
            m_fd = 0;
            if ((m_age % R) == R - 1) begin
                m_above = next_above(m_s_data, m_s_en, m_cur);
                m_bound = (m_above < 0);
                if (m_bound && m_pend) begin
                    m_s_data = m_p_data; m_s_dp = m_p_dp; m_s_en = m_p_en; m_pend = 0;
                end
                m_above = next_above(m_s_data, m_s_en, m_cur);
                if (m_above < 0) m_above = lowest_on(m_s_data, m_s_en);
                m_blank = (m_above < 0);
                m_cur   = m_blank ? 0 : m_above;
                m_fd    = m_bound;
            end
            if (bus.load) begin
                m_p_data = bus.data_in; m_p_dp = bus.dp_in; m_p_en = bus.digit_en; m_pend = 1;
            end
            m_age++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (tb_go) begin
            chk("pending", {31'd0, bus.pending}, {31'd0, m_pend});
            chk("active", {29'd0, bus.active}, m_cur);
            chk("num", {28'd0, bus.num}, (m_s_data >> (4 * m_cur)) & 32'hF);
            chk("dp_ctrl", {31'd0, bus.dp_ctrl}, {31'd0, ~m_s_dp[m_cur]});
            chk("blank", {31'd0, bus.blank}, {31'd0, m_blank});
            chk("frame_done", {31'd0, bus.frame_done}, {31'd0, m_fd});
        end
    end

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        @(negedge clk);
        bus.data_in = d; bus.dp_in = dp; bus.digit_en = en; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_done;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pending"}, {31'd0, bus.pending}, 32'd0);
        chk({tag, "_active"}, {29'd0, bus.active}, 32'd0);
        chk({tag, "_num"}, {28'd0, bus.num}, 32'd0);
        chk({tag, "_dp_ctrl"}, {31'd0, bus.dp_ctrl}, 32'd1);
        chk({tag, "_blank"}, {31'd0, bus.blank}, 32'd1);
        chk({tag, "_fd"}, {31'd0, bus.frame_done}, 32'd0);
    endtask

    int exp_sp[4] = '{2, 5, 2, 5};

    initial begin
        int  c;
        int  mx;
        bit  seen;
        logic [2:0] a0;
        reset_n = 1'b0;
        bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.digit_en = '0;
        repeat (3) @(negedge clk);
        tb_go = 1'b1;
        chk_reset_vals("por");
        reset_n = 1'b1;

        // Full scan of all eight digits.
        do_load(32'h76543210, 8'h01, 8'hFF);
        chk("load_pending", {31'd0, bus.pending}, 32'd1);
        wait_fd("fs_fd1");
        chk("fs_pending", {31'd0, bus.pending}, 32'd0);
        chk("fs_active1", {29'd0, bus.active}, 32'd1);
        chk("fs_num1", {28'd0, bus.num}, 32'd1);
        chk("fs_dp1", {31'd0, bus.dp_ctrl}, 32'd1);
        chk("fs_blank", {31'd0, bus.blank}, 32'd0);
        a0 = bus.active;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.active == a0 && c < 20);
        chk("slot_len", c, R);
        wait_fd("fs_fd2");
        chk("fs_wrap_active", {29'd0, bus.active}, 32'd0);
        chk("fs_wrap_num", {28'd0, bus.num}, 32'd0);
        chk("fs_wrap_dp", {31'd0, bus.dp_ctrl}, 32'd0);

        // Asynchronous reset mid-scan.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        reset_n = 1'b1;

        // Sparse enable, then no digits at all.
        do_load(32'h87654321, 8'h00, 8'h24);
        wait_fd("sp_fd");
        for (int k = 0; k < 4; k++) begin
            if (k != 0) repeat (R) @(negedge clk);
            chk("sparse_active", {29'd0, bus.active}, exp_sp[k]);
        end
        do_load(32'h87654321, 8'h00, 8'h00);
        wait_fd("none_fd");
        chk("none_blank", {31'd0, bus.blank}, 32'd1);
        chk("none_active", {29'd0, bus.active}, 32'd0);

        // No tearing: new image appears only at the wrap.
        do_load(32'h11111111, 8'h00, 8'hFF);
        wait_fd("tear_fd0");
        repeat (8) @(negedge clk);
        do_load(32'hFFFFFFFF, 8'h00, 8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_done;
            if (!seen) begin
                chk("tear_old", {28'd0, bus.num}, 32'h1);
                chk("tear_pend", {31'd0, bus.pending}, 32'd1);
            end
        end
        chk("tear_fd", {31'd0, seen}, 32'd1);
        chk("tear_new", {28'd0, bus.num}, 32'hF);

        // Back-to-back loads, then a load landing on the boundary tick.
        do_load(32'h22222222, 8'h00, 8'hFF);
        do_load(32'h33333333, 8'h00, 8'hFF);
        repeat (27) @(negedge clk);
        bus.data_in = 32'h44444444; bus.dp_in = 8'h00; bus.digit_en = 8'hFF; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("bb_fd", {31'd0, bus.frame_done}, 32'd1);
        chk("bb_num", {28'd0, bus.num}, 32'h3);
        chk("bb_pending", {31'd0, bus.pending}, 32'd1);
        wait_fd("bb_fd2");
        chk("bb_num2", {28'd0, bus.num}, 32'h4);
        chk("bb_pending2", {31'd0, bus.pending}, 32'd0);

        // Leading zeros: suppressed when the option is built in, shown otherwise.
        do_load(32'h00000A05, 8'h00, 8'hFF);
        wait_fd("lz_fd");
        mx = 0;
        repeat (40) begin
            @(negedge clk);
            if (int'(bus.active) > mx) mx = int'(bus.active);
        end
        chk("lz_max_active", mx, LZB ? 2 : 7);
        do_load(32'h00000000, 8'h00, 8'hFF);
        wait_fd("zero_fd");
        chk("zero_active", {29'd0, bus.active}, 32'd0);
        chk("zero_num", {28'd0, bus.num}, 32'd0);
        chk("zero_blank", {31'd0, bus.blank}, 32'd0);

        // Random loads and occasional asynchronous resets.
        for (int it = 0; it < 2500; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 1) bus.data_in = $urandom;
                else bus.data_in = $urandom >> (4 * $urandom_range(1, 7));
                bus.dp_in = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       bus.digit_en = 8'hFF;
                    1:       bus.digit_en = 8'($urandom);
                    2:       bus.digit_en = 8'(32'd1 << $urandom_range(0, 7));
                    default: bus.digit_en = 8'h00;
                endcase
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
        end
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
